// File: rtl/dma_channel_sched.sv
// rtl/dma_channel_sched.sv - two-channel DMA burst scheduler (round-robin tie-break under DMA_SCHED_RR_EN)
module dma_channel_sched #(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8,
    parameter int STRIDE = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              req1,
    input  logic [ADDR_W-1:0] start_addr1,
    input  logic [LEN_W-1:0]  len1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] start_addr2,
    input  logic [LEN_W-1:0]  len2,
    input  logic              ready_IN,
    output logic              gnt1,
    output logic              gnt2,
    output logic              done1,
    output logic              done2,
    output logic              valid,
    output logic              End,
    output logic              act1,
    output logic              act2,
    output logic [ADDR_W-1:0] addr_COM,
    output logic              busy
);

    // S_ZERO is the grant cycle of an empty burst, so done still lands one cycle after gnt
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ZERO, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               gnt1_q, gnt1_d, gnt2_q, gnt2_d;
    logic               done1_q, done1_d, done2_q, done2_d;
    logic               valid_q, valid_d, end_q, end_d;
    logic               act1_q, act1_d, act2_q, act2_d;
    logic               busy_q, busy_d;
    logic               own2_q, own2_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;

    logic               any_req;
    logic               sel2;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               accept;

`ifdef DMA_SCHED_RR_EN
    logic               prio2_q;
`endif

    // winner selection: a lone requester always wins, a tie goes to the preferred channel
    always_comb begin
        any_req = req1 | req2;
`ifdef DMA_SCHED_RR_EN
        sel2 = req2 & (~req1 | prio2_q);
`else
        sel2 = req2 & ~req1;
`endif
        sel_addr = sel2 ? start_addr2 : start_addr1;
        sel_len  = sel2 ? len2 : len1;
        accept   = valid_q & ready_IN;
    end

    // state register and all registered outputs/datapath
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            gnt1_q  <= 1'b0;
            gnt2_q  <= 1'b0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            act1_q  <= 1'b0;
            act2_q  <= 1'b0;
            busy_q  <= 1'b0;
            own2_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
`ifdef DMA_SCHED_RR_EN
            prio2_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt1_q  <= gnt1_d;
            gnt2_q  <= gnt2_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            act1_q  <= act1_d;
            act2_q  <= act2_d;
            busy_q  <= busy_d;
            own2_q  <= own2_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
`ifdef DMA_SCHED_RR_EN
            // the channel just served loses the next tie (empty bursts count too)
            if (state_q == S_DONE) begin
                prio2_q <= ~own2_q;
            end
`endif
        end
    end

    // next-state sequencing of one burst at a time
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (any_req) state_d = (sel_len == '0) ? S_ZERO : S_XFER;
            S_XFER: if (accept && end_q) state_d = S_DONE;
            S_ZERO: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // next values of registered outputs; beat fields hold while ready_IN is low
    always_comb begin
        gnt1_d  = 1'b0;
        gnt2_d  = 1'b0;
        done1_d = 1'b0;
        done2_d = 1'b0;
        valid_d = valid_q;
        end_d   = end_q;
        act1_d  = act1_q;
        act2_d  = act2_q;
        own2_d  = own2_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    own2_d  = sel2;
                    gnt1_d  = ~sel2;
                    gnt2_d  = sel2;
                    addr_d  = sel_addr;
                    rem_d   = sel_len;
                    valid_d = (sel_len != '0);
                    end_d   = (sel_len == LEN_W'(1));
                    act1_d  = ~sel2 & (sel_len != '0);
                    act2_d  = sel2 & (sel_len != '0);
                end
            end
            S_XFER: begin
                if (accept) begin
                    if (end_q) begin
                        valid_d = 1'b0;
                        end_d   = 1'b0;
                        act1_d  = 1'b0;
                        act2_d  = 1'b0;
                        done1_d = ~own2_q;
                        done2_d = own2_q;
                    end else begin
                        addr_d = addr_q + ADDR_W'(STRIDE);
                        rem_d  = rem_q - LEN_W'(1);
                        end_d  = (rem_q == LEN_W'(2));
                    end
                end
            end
            S_ZERO: begin
                done1_d = ~own2_q;
                done2_d = own2_q;
            end
            default: begin
            end
        endcase
    end

    assign gnt1     = gnt1_q;
    assign gnt2     = gnt2_q;
    assign done1    = done1_q;
    assign done2    = done2_q;
    assign valid    = valid_q;
    assign End      = end_q;
    assign act1     = act1_q;
    assign act2     = act2_q;
    assign addr_COM = addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dma_channel_sched.sv
// tb/tb_dma_channel_sched.sv - scoreboard bench for dma_channel_sched
module tb_dma_channel_sched;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        req1 = 1'b0, req2 = 1'b0, ready_IN = 1'b1;
    logic [63:0] start_addr1 = '0, start_addr2 = '0;
    logic [7:0]  len1 = '0, len2 = '0;
    logic        gnt1, gnt2, done1, done2, valid, End, act1, act2, busy;
    logic [63:0] addr_COM;

    dma_channel_sched dut (
        .clk(clk), .reset_L(reset_L),
        .req1(req1), .start_addr1(start_addr1), .len1(len1),
        .req2(req2), .start_addr2(start_addr2), .len2(len2),
        .ready_IN(ready_IN),
        .gnt1(gnt1), .gnt2(gnt2), .done1(done1), .done2(done2),
        .valid(valid), .End(End), .act1(act1), .act2(act2),
        .addr_COM(addr_COM), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [2:0]  gq[$];
    logic [2:0]  dq[$];
    logic [66:0] bq[$];

    int          beats_seen   = 0;
    int          valid_cycles = 0;
    bit          stall_prev   = 0;
    bit          end_prev     = 0;
    logic [67:0] stall_snap;

    task automatic chk_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // output monitor: pops expectations whenever the DUT produces a grant, beat or done
    always @(negedge clk) begin
        logic [66:0] eb;
        logic [2:0]  eg;
        if (reset_L) begin
            chk_eq("exclusive", 72'({gnt1 & gnt2, done1 & done2, act1 & act2}), 72'd0);
            if (stall_prev)
                chk_eq("stall_hold", 72'({valid, End, act1, act2, addr_COM}), 72'(stall_snap));
            if (end_prev)
                chk_eq("done_after_end", 72'(done1 | done2), 72'd1);
            if (gnt1 | gnt2) begin
                if (gq.size() == 0) chk_eq("gnt_unexpected", 72'({gnt1, gnt2}), 72'd0);
                else begin
                    eg = gq.pop_front();
                    chk_eq("gnt", 72'({gnt2, valid, busy}), 72'(eg));
                end
            end
            if (done1 | done2) begin
                if (dq.size() == 0) chk_eq("done_unexpected", 72'({done1, done2}), 72'd0);
                else begin
                    eg = dq.pop_front();
                    chk_eq("done", 72'({done2, valid, busy}), 72'(eg));
                end
            end
            if (valid) valid_cycles++;
            if (valid && ready_IN) begin
                if (bq.size() == 0) chk_eq("beat_unexpected", 72'(addr_COM), 72'h1_0000_0000_0000_0000);
                else begin
                    eb = bq.pop_front();
                    chk_eq("beat", 72'({act1, act2, End, addr_COM}), 72'(eb));
                end
                beats_seen++;
            end
            stall_prev = valid && !ready_IN;
            stall_snap = {valid, End, act1, act2, addr_COM};
            end_prev   = valid && ready_IN && End;
        end else begin
            stall_prev = 0;
            end_prev   = 0;
        end
    end

    task automatic push_burst(input bit ch, input logic [63:0] a, input logic [7:0] l);
        gq.push_back({ch, l != 8'd0, 1'b1});
        for (int i = 0; i < int'(l); i++)
            bq.push_back({~ch, ch, (i == int'(l) - 1), a + 64'(i) * 64'd8});
        dq.push_back({ch, 1'b0, 1'b1});
    endtask

    task automatic run_burst(input bit ch, input logic [63:0] a, input logic [7:0] l,
                             input int stall_at, input int stall_n, input bit rnd);
        int base, vc0, stalled;
        bit got;
        push_burst(ch, a, l);
        @(posedge clk); #1;
        base = beats_seen; vc0 = valid_cycles; stalled = 0; got = 0;
        if (ch) begin req2 = 1; start_addr2 = a; len2 = l; end
        else    begin req1 = 1; start_addr1 = a; len1 = l; end
        ready_IN = 1;
        for (int cyc = 0; cyc < 300 && !got; cyc++) begin
            @(posedge clk); #1;
            if (gnt1 | gnt2) begin req1 = 0; req2 = 0; end
            if (done1 | done2) got = 1;
            if (rnd) ready_IN = ($urandom_range(0, 2) != 0);
            else if (valid && (beats_seen - base) == stall_at && stalled < stall_n) begin
                ready_IN = 0; stalled++;
            end else ready_IN = 1;
        end
        if (!got) chk_eq("done_timeout", 72'd0, 72'd1);
        ready_IN = 1;
        if (!rnd) chk_eq("valid_cycles", 72'(valid_cycles - vc0), 72'(int'(l) + stalled));
        @(posedge clk); #1;
        chk_eq("busy_after_done", 72'(busy), 72'd0);
    endtask

    initial begin
        int ndone;
        bit got;
        int base;
        bit chs[4];

        // reset
        reset_L = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_outs", 72'({gnt1, gnt2, done1, done2, valid, End, act1, act2, busy, addr_COM}), 72'd0);
        reset_L = 1;
        @(posedge clk); #1;
        chk_eq("idle_outs", 72'({gnt1, gnt2, done1, done2, valid, End, act1, act2, busy, addr_COM}), 72'd0);

        // basic burst, then the same burst with a two-cycle stall on beat 2
        run_burst(0, 64'h1000, 8'd3, -1, 0, 0);
        run_burst(0, 64'h1000, 8'd3, 1, 2, 0);

        // simultaneous requests, len=1 each; req1 dropped after four bursts
`ifdef DMA_SCHED_RR_EN
        chs = '{0, 1, 0, 1};
`else
        chs = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) push_burst(chs[i], chs[i] ? 64'h3000 : 64'h2000, 8'd1);
        push_burst(1, 64'h3000, 8'd1);
        @(posedge clk); #1;
        start_addr1 = 64'h2000; len1 = 8'd1; start_addr2 = 64'h3000; len2 = 8'd1;
        req1 = 1; req2 = 1; ready_IN = 1; ndone = 0;
        for (int cyc = 0; cyc < 400 && ndone < 5; cyc++) begin
            @(posedge clk); #1;
            if (gnt2 && ndone == 4) req2 = 0;
            if (done1 | done2) begin
                ndone++;
                if (ndone == 4) req1 = 0;
            end
        end
        chk_eq("tie_dones", 72'(ndone), 72'd5);
        req1 = 0; req2 = 0;

        // address wrap on channel 2, then an empty burst on channel 1
        run_burst(1, 64'hFFFF_FFFF_FFFF_FFF8, 8'd2, -1, 0, 0);
        run_burst(0, 64'h4000, 8'd0, -1, 0, 0);

        // reset during beat 2 of a 4-beat burst: no done, no further beats
        gq.push_back({1'b0, 1'b1, 1'b1});
        bq.push_back({1'b1, 1'b0, 1'b0, 64'h5000});
        @(posedge clk); #1;
        start_addr1 = 64'h5000; len1 = 8'd4; req1 = 1; ready_IN = 1;
        base = beats_seen; got = 0;
        for (int cyc = 0; cyc < 50 && !got; cyc++) begin
            @(posedge clk); #1;
            if (gnt1) req1 = 0;
            if (valid && (beats_seen - base) == 1) begin
                reset_L = 0; ready_IN = 0; got = 1;
            end
        end
        chk_eq("reset_reached_beat2", 72'(got), 72'd1);
        @(posedge clk); #1;
        chk_eq("midburst_reset_outs", 72'({gnt1, gnt2, done1, done2, valid, End, act1, act2, busy, addr_COM}), 72'd0);
        reset_L = 1; ready_IN = 1;
        repeat (4) @(posedge clk);
        #1;
        chk_eq("post_reset_idle", 72'({busy, valid, done1, done2}), 72'd0);
        run_burst(0, 64'h5000, 8'd2, -1, 0, 0);

        // a few bursts under random backpressure
        for (int i = 0; i < 4; i++)
            run_burst(i[0], 64'h8000 + 64'(i) * 64'h100, 8'($urandom_range(1, 5)), -1, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk_eq("queues_empty", 72'({gq.size() == 0, dq.size() == 0, bq.size() == 0}), 72'b111);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
